// File: rtl/lzc_pkg.sv
`default_nettype none
// ==========================================================================
// lzc_pkg: shared types and helpers for the LZC / normalise datapath
// Revision: 1.0
// ==========================================================================
package lzc_pkg;

  // Leaf/merge node pair: p = count bit(s) so far, v = any one seen
  typedef struct packed {
    logic p;
    logic v;
  } lzc_node_t;

  typedef enum logic {
    ALIGN_EXACT = 1'b0,
    ALIGN_EVEN  = 1'b1
  } align_mode_e;

  function automatic int lzc_width(input int width);
    return $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lzc_tree.sv
`default_nettype none
// ==========================================================================
// lzc_tree: combinational leading-zero count built from 2-bit leaf cells
// Revision: 1.0
// ==========================================================================
module lzc_leaf2
  import lzc_pkg::*;
(
  input  logic [1:0] pair,
  output lzc_node_t  node
);

  assign node.p = ~pair[1];
  assign node.v = |pair;

endmodule

module lzc_tree
  import lzc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]         bits,
  output logic [$clog2(WIDTH)-1:0] cnt,
  output logic                     valid
);

  generate
    if (WIDTH == 2) begin : g_leaf
      lzc_node_t node;

      lzc_leaf2 u_leaf (
        .pair (bits),
        .node (node)
      );

      assign cnt   = node.p;
      assign valid = node.v;
    end else begin : g_merge
      localparam int HALF = WIDTH / 2;
      localparam int HW   = $clog2(HALF);

      logic [HW-1:0] hi_cnt;
      logic [HW-1:0] lo_cnt;
      logic          hi_v;
      logic          lo_v;

      lzc_tree #(.WIDTH(HALF)) u_hi (
        .bits  (bits[WIDTH-1:HALF]),
        .cnt   (hi_cnt),
        .valid (hi_v)
      );

      lzc_tree #(.WIDTH(HALF)) u_lo (
        .bits  (bits[HALF-1:0]),
        .cnt   (lo_cnt),
        .valid (lo_v)
      );

      // Upper half wins whenever it holds a one; otherwise all its bits are leading zeros
      assign cnt   = hi_v ? {1'b0, hi_cnt} : {1'b1, lo_cnt};
      assign valid = hi_v | lo_v;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/lzc_norm_pipe.sv
`default_nettype none
// ==========================================================================
// lzc_norm_pipe: two-stage leading-zero count and mantissa normalise
// Revision: 1.0
// ==========================================================================
module lzc_norm_pipe
  import lzc_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int EXP_W  = 8,
  parameter int ALIGN2 = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_mant,
  input  logic [EXP_W-1:0]         in_exp,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_mant,
  output logic [EXP_W-1:0]         out_exp,
  output logic [$clog2(WIDTH)-1:0] out_lzc,
  output logic                     out_zero,
  output logic                     out_uflow
);

  localparam int          LZC_W     = lzc_width(WIDTH);
  localparam int          CMP_W     = (EXP_W > LZC_W) ? EXP_W : LZC_W;
  localparam align_mode_e MODE      = (ALIGN2 != 0) ? ALIGN_EVEN : ALIGN_EXACT;
  localparam logic        EVEN_ONLY = (MODE == ALIGN_EVEN);
  localparam logic [LZC_W-1:0] EVEN_MASK = {{(LZC_W-1){1'b1}}, ~EVEN_ONLY};

  // ---------------- handshake ----------------
  logic s1_valid;
  logic s2_valid;
  logic s1_advance;

  assign s1_advance = !s2_valid | out_ready;
  assign in_ready   = !s1_valid | s1_advance;

  // ---------------- stage 1: count ----------------
  logic [LZC_W-1:0] tree_cnt;
  logic             tree_valid;

  lzc_tree #(.WIDTH(WIDTH)) u_tree (
    .bits  (in_mant),
    .cnt   (tree_cnt),
    .valid (tree_valid)
  );

  logic [WIDTH-1:0] s1_mant;
  logic [EXP_W-1:0] s1_exp;
  logic [LZC_W-1:0] s1_lzc;
  logic             s1_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mant  <= '0;
      s1_exp   <= '0;
      s1_lzc   <= '0;
      s1_zero  <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mant <= in_mant;
        s1_exp  <= in_exp;
        s1_lzc  <= tree_cnt & EVEN_MASK;
        s1_zero <= ~tree_valid;
      end
    end
  end

  // ---------------- stage 2: clamp and shift ----------------
  logic             clamp;
  logic [LZC_W-1:0] shift;
  logic [EXP_W-1:0] exp_adj;
  logic [WIDTH-1:0] mant_adj;

  // When clamped, exp < L <= WIDTH-1, so the exponent fits in the shift width
  always_comb begin
    clamp    = CMP_W'(s1_lzc) > CMP_W'(s1_exp);
    shift    = clamp ? (LZC_W'(s1_exp) & EVEN_MASK) : s1_lzc;
    exp_adj  = s1_exp - EXP_W'(shift);
    mant_adj = s1_mant << shift;
  end

  logic [WIDTH-1:0] s2_mant;
  logic [EXP_W-1:0] s2_exp;
  logic [LZC_W-1:0] s2_lzc;
  logic             s2_zero;
  logic             s2_uflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_mant  <= '0;
      s2_exp   <= '0;
      s2_lzc   <= '0;
      s2_zero  <= 1'b0;
      s2_uflow <= 1'b0;
    end else if (s1_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        if (s1_zero) begin
          s2_mant  <= '0;
          s2_exp   <= '0;
          s2_lzc   <= '0;
          s2_zero  <= 1'b1;
          s2_uflow <= 1'b0;
        end else begin
          s2_mant  <= mant_adj;
          s2_exp   <= exp_adj;
          s2_lzc   <= shift;
          s2_zero  <= 1'b0;
          s2_uflow <= clamp;
        end
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_mant  = s2_mant;
  assign out_exp   = s2_exp;
  assign out_lzc   = s2_lzc;
  assign out_zero  = s2_zero;
  assign out_uflow = s2_uflow;

endmodule
`default_nettype wire

// File: doc/lzc_norm_pipe.md
Name: lzc_norm_pipe

Overview:
- Two-stage pipelined leading-zero count and normalise stage for the approximate FP datapath.
- Builds a LZC tree from 2-bit leaf cells, left-shifts the mantissa by the count and decrements the exponent.
- Sits downstream of the adder's mantissa subtract and upstream of rounding/pack.
- valid/ready on both sides; full throughput under continuous flow.

Parameters:
- WIDTH, 16, mantissa width; power of two, >= 4.
- EXP_W, 8, exponent width.
- ALIGN2, 0, 1 = approximate mode: the count's LSB is forced to 0, so shifts are even-only (2-bit aligned).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream data valid
- in_ready  out  1  stage can accept
- in_mant  in  WIDTH  unnormalised mantissa; bit WIDTH-1 is MSB
- in_exp  in  EXP_W  unbiased-stored exponent before normalise
- out_valid  out  1  result valid
- out_ready  in  1  downstream can accept
- out_mant  out  WIDTH  normalised mantissa
- out_exp  out  EXP_W  adjusted exponent
- out_lzc  out  $clog2(WIDTH)  shift amount actually applied
- out_zero  out  1  input mantissa was all zeros
- out_uflow  out  1  shift was clamped by the exponent

Behaviour:
- Reset (async, rst=1): both stage valid flags clear.
  - out_valid=0; out_mant, out_exp, out_lzc, out_zero, out_uflow = 0.
  - in_ready=1 from the first clk edge after rst deasserts.
- Transfers:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Latency: exactly 2 cycles from input transfer to out_valid with no stall. Throughput: 1 per cycle.
- Stage 1 (S1):
  - Computes raw count L via leaf/merge tree.
  - Each leaf sees the pair (mant[2k+1], mant[2k]), with leaf b[0] = mant[2k+1] (the higher-significance bit). Leaf p = !b[0], v = b[0]|b[1].
  - Merge node: if the upper half is valid, take the upper count with a 0 prefix; else take the lower count with a 1 prefix. Valid is the OR of both halves.
  - If ALIGN2=1: L = L & ~1.
  - Registers mant, exp, L, zero (root v=0).
- Stage 2 (S2):
  - If zero: out_mant=0, out_exp=0, out_lzc=0, out_zero=1, out_uflow=0.
  - Else if L <= in_exp: shift S=L, out_exp=exp-L, out_uflow=0.
  - Else: S=exp, then S=S&~1 if ALIGN2. Set out_exp=exp-S, out_uflow=1.
  - out_mant = mant << S; zeros fill from the right. out_lzc = S.
- Backpressure:
  - Each stage holds its data while the stage below is full and not advancing.
  - in_ready = !s1_valid | s1_advance, where s1_advance = !s2_valid | out_ready.
  - There are no skid buffers and no bubble insertion.
- Outputs held stable while out_valid & !out_ready.
- Simultaneous input and output transfer in the same cycle is allowed with no loss or duplication.
- Reset asserted mid-operation discards all in-flight data immediately.
- Width rules:
  - Exponent subtract is unsigned. The clamp guarantees no wrap.
  - L has max WIDTH-1 for nonzero input.

Decomposition:
- Shared package lzc_pkg:
  - function/localparam LZC_W = $clog2(WIDTH);
  - typedef for the (p, v) node pair;
  - ALIGN2 mode enumeration.
- One natural sub-module: lzc_tree (combinational, parameter WIDTH).
  - Instantiates the existing 2-bit leaf cells plus recursive merge nodes.
  - Outputs count and valid.
- Pipeline control, clamp and shifter stay in lzc_norm_pipe.

Test Plan:
- WIDTH=16, ALIGN2=0: mant=0x0123, exp=20, out_ready=1. Expect after 2 cycles: out_mant=0x91 80, out_exp=13, out_lzc=7, out_zero=0, out_uflow=0. (0x0123<<7 = 0x9180.)
- Same input with ALIGN2=1. Expect out_lzc=6, out_mant=0x48C0, out_exp=14 (MSB remains 0 by design).
- mant=0x0001, exp=5, ALIGN2=0. Expect S=5, out_mant=0x0020, out_exp=0, out_uflow=1. Repeat with ALIGN2=1: expect S=4, out_exp=1, out_mant=0x0010.
- mant=0x0000, exp=9. Expect out_zero=1, out_mant=0, out_exp=0, out_lzc=0.
- Stream 8 back-to-back inputs; hold out_ready=0 for cycles 3-5.
  - Expect in_ready=0 once both stages are full.
  - Expect outputs stable while stalled, all 8 results in order, none dropped or duplicated.
- Assert rst mid-stream with 2 items in flight. Expect out_valid=0 immediately (async), no stale output after release, first new input emerges 2 cycles after acceptance.
